clocked_adder: RTL and testbench
================================

# clocked_adder

Registered unsigned adder: samples two WIDTH-bit operands on each rising clock edge and presents their full-precision sum, including carry-out, from an output register. It is the reference datapath block for the power-estimation flow. It therefore uses an explicit, structurally visible ripple-carry chain so that switching activity per bit slice can be traced in waveform dumps.

## Interface
Parameters:
- WIDTH, default 4, operand width in bits (minimum 1).

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset; clears the output register.
- A  input  WIDTH  unsigned operand A.
- B  input  WIDTH  unsigned operand B.
- sum  output  WIDTH+1  registered unsigned sum A+B; the MSB is carry-out.

## Operation
- Combinational core: ripple-carry chain of WIDTH full-adder slices.
  - Slice i: s[i] = A[i] ^ B[i] ^ c[i]; c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i])).
  - Carry-in c[0] is tied to 0.
  - Carry-out c[WIDTH] forms the MSB of the result.
- Implement the slices as individually instantiated or generated full-adder cells. No behavioural "+" operator in the datapath; each slice must remain visible in hierarchy and dumps.
- Output register: a WIDTH+1-bit register captures {c[WIDTH], s[WIDTH-1:0]} on every rising clk edge. There is no enable; the register loads every cycle.
- Arithmetic is unsigned and never overflows: the maximum result is 2*(2^WIDTH - 1), which fits in WIDTH+1 bits.
- No internal state other than the output register. No handshake or valid signal.

## Timing
- Reset: when rst is asserted, sum goes to 0 immediately, without waiting for a clock edge. sum holds 0 for as long as rst is high.
- Reset release: the first rising edge after rst is deasserted loads A+B.
- Latency: 1 cycle. sum reflects the A and B values sampled at the most recent rising edge.
- Changes on A or B between edges do not affect sum until the next rising edge. sum is glitch-free between edges.
- Inputs that change coincident with a rising edge are undefined for that edge. Drive stimulus away from the active edge, for example on the falling edge.
- rst asserted mid-stream: the sum being presented is discarded and sum reads 0. Normal loading resumes on the first edge after release.
- X on A or B propagates only into the bits whose carry chain it reaches. Reset always clears sum to a defined 0.

## Test plan
- Reset: drive A=4'hF, B=4'hF, assert rst asynchronously between edges -> sum=0 immediately, and stays 0 across edges while rst is high.
- Basic sequence (drive on the falling edge): A=2,B=3 -> sum=5 after the next rising edge; then A=4,B=5 -> sum=9; then A=8,B=6 -> sum=14. Each result appears exactly one edge after its inputs are applied.
- Carry and overflow: A=15,B=15 -> sum=30 (5'b11110); A=15,B=1 -> sum=16 (full carry ripple through every slice); A=0,B=0 -> sum=0.
- Inter-edge stability: change A from 3 to 7 and back to 3 within one clock low/high phase without crossing an edge -> sum stays unchanged until the next rising edge, then equals 3+B.
- Reset mid-operation: with sum=9, pulse rst for half a cycle between edges -> sum=0 at once. On the first edge after release with A=1,B=2 -> sum=3.
- Exhaustive (WIDTH=4): apply all 256 A/B pairs, one per cycle -> each sum equals A+B one cycle later, with no mismatches.

Source files
------------

// File: rtl/clocked_adder.sv
// Registered unsigned adder built from a generated ripple-carry chain of
// full-adder cells, so each bit slice stays visible in hierarchy and dumps.

module clocked_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module clocked_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   sum
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    clocked_adder_fa u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Carry-out of the last slice becomes the result MSB; loads every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else     sum <= {c[WIDTH], s};
  end
endmodule

// File: tb/tb_clocked_adder.sv
// Directed and exhaustive bench for clocked_adder (WIDTH=4) against an
// arithmetic reference model checked every cycle, plus literal expectations.

module tb_clocked_adder;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W:0]   sum;

  logic [W:0]   exp_sum;
  logic         chk_en = 1'b0;
  int           n_tests = 0;
  int           n_fail  = 0;

  clocked_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .sum (sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: sum is A+B from the last edge, zero whenever reset is high.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_sum <= '0;
    else     exp_sum <= {1'b0, A} + {1'b0, B};
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) check("model", sum, exp_sum);
  end

  task automatic drive(input int a, input int b);
    @(negedge clk);
    A = W'(a);
    B = W'(b);
  endtask

  task automatic expect_lit(input string name, input int v);
    @(posedge clk);
    #2;
    check(name, sum, (W+1)'(v));
  endtask

  initial begin
    // Async reset with all-ones operands already loaded.
    A = 4'hF;
    B = 4'hF;
    @(posedge clk);
    #1;
    check("preload_30", sum, 5'd30);
    #1;
    rst = 1'b1;
    #1;
    check("rst_immediate", sum, 5'd0);
    chk_en = 1'b1;
    expect_lit("rst_hold0", 0);
    expect_lit("rst_hold1", 0);
    @(negedge clk);
    rst = 1'b0;
    A = 4'd2;
    B = 4'd3;
    expect_lit("basic_5", 5);
    drive(4, 5);
    expect_lit("basic_9", 9);
    drive(8, 6);
    expect_lit("basic_14", 14);

    // Carry chain extremes.
    drive(15, 15);
    expect_lit("carry_30", 30);
    drive(0, 0);
    expect_lit("zero", 0);
    drive(15, 1);
    expect_lit("ripple_16", 16);

    // Operand churn between edges must not reach sum.
    @(negedge clk);
    A = 4'd3;
    B = 4'd9;
    #1 A = 4'd7;
    #1 check("stable_mid", sum, 5'd16);
    #1 A = 4'd3;
    #1 check("stable_late", sum, 5'd16);
    expect_lit("stable_after", 12);

    // Mid-stream reset pulse between edges.
    drive(4, 5);
    expect_lit("pre_rst_9", 9);
    rst = 1'b1;
    #1 check("mid_rst_zero", sum, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    A = 4'd1;
    B = 4'd2;
    expect_lit("post_rst_3", 3);

    // Exhaustive sweep, checked cycle by cycle against the model.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        drive(a, b);
    expect_lit("last_pair_30", 30);
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
